instr_fetch: RTL and testbench

Instruction fetch stage for the single-cycle MIPS datapath, sitting directly upstream of the main `control` decoder. It owns the PC, issues requests to instruction memory over a req/ack handshake, registers the returned word, and presents `opcode` and the full instruction to decode. It computes the next PC from the `Jump`/`Branch` outputs of control and the branch outcome from the ALU.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/next_pc_sel.sv | 32 +++
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, jump-select and fetch-state encodings
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] JUMP_NONE = 2'd0;
    localparam logic [1:0] JUMP_IMM  = 2'd1;
    localparam logic [1:0] JUMP_REG  = 2'd2;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_EXEC = 3'd3,
        S_HALT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC select: jump, register jump, taken branch, sequential
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [1:0]  jump,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [31:0] reg_target,
    output logic [31:0] next_pc
);

    logic [31:0] branch_off;
    logic        unused_opcode_bits;

    assign branch_off         = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign unused_opcode_bits = ^instr[31:26];

    // Reserved jump encoding 3 falls through to the branch/sequential path.
    always_comb begin
        next_pc = pc_plus4;
        if (jump == JUMP_IMM) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (jump == JUMP_REG) begin
            next_pc = reg_target;
        end else if (branch && branch_taken) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, imem req/ack, instruction register; option FETCH_ALIGN_CHECK_EN
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  jump,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [31:0] reg_target,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    fetch_state_t state;
    logic [31:0]  next_pc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign opcode    = instr[31:26];

    next_pc_sel u_next_pc_sel (
        .pc_plus4     (pc_plus4),
        .instr        (instr),
        .jump         (jump),
        .branch       (branch),
        .branch_taken (branch_taken),
        .reg_target   (reg_target),
        .next_pc      (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_RST;
            pc          <= RESET_PC;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign    <= 1'b0;
`endif
        end else begin
            case (state)
                S_RST: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ, S_WAIT: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (next_pc[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                            state    <= S_HALT;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= S_REQ;
                        end
`else
                        // Low bits dropped so a bad register target still fetches word-aligned.
                        pc       <= next_pc & ~32'h3;
                        imem_req <= 1'b1;
                        state    <= S_REQ;
`endif
                    end
                end
                S_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= S_RST;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic [1:0]  jump = 2'd0;
    logic        branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] reg_target = '0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    instr_fetch #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .jump         (jump),
        .branch       (branch),
        .branch_taken (branch_taken),
        .reg_target   (reg_target),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign     (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, check its address, hold it lat cycles, then ack once.
    task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] word, input int lat);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk({tag, "/req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "/addr"}, imem_addr, addr);
        for (int i = 0; i < lat; i++) begin
            step();
            chk({tag, "/hold_req"}, {31'd0, imem_req}, 32'd1);
            chk({tag, "/hold_addr"}, imem_addr, addr);
            chk({tag, "/hold_valid"}, {31'd0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk({tag, "/valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "/instr"}, instr, word);
        chk({tag, "/req_low"}, {31'd0, imem_req}, 32'd0);
    endtask

    task automatic redirect(input logic [1:0] j, input logic b, input logic t, input logic [31:0] tgt);
        jump = j;
        branch = b;
        branch_taken = t;
        reg_target = tgt;
        step();
        jump = 2'd0;
        branch = 1'b0;
        branch_taken = 1'b0;
        reg_target = 32'h0;
    endtask

    initial begin
        step();
        step();
        chk("rst/req", {31'd0, imem_req}, 32'd0);
        chk("rst/addr", imem_addr, RPC);
        chk("rst/instr", instr, 32'h0);
        chk("rst/opcode", {26'd0, opcode}, 32'd0);
        chk("rst/valid", {31'd0, instr_valid}, 32'd0);
        chk("rst/pc", pc, RPC);
        chk("rst/pc4", pc_plus4, RPC + 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst/misalign", {31'd0, misalign}, 32'd0);
`endif

        rst_n = 1'b1;
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        serve("addi", RPC, 32'h2008_0005, 0);
        chk("addi/opcode", {26'd0, opcode}, 32'd8);
        chk("addi/pc", pc, 32'h0040_0000);
        chk("addi/pc4", pc_plus4, 32'h0040_0004);

        redirect(2'd0, 1'b0, 1'b0, 32'h0);
        // stall while requesting has no effect; it then holds the instruction in EXEC
        stall = 1'b1;
        serve("lat3", 32'h0040_0004, 32'h0810_0008, 2);
        jump = 2'd2;
        reg_target = 32'hDEAD_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall/req", {31'd0, imem_req}, 32'd0);
            chk("stall/pc", pc, 32'h0040_0004);
            chk("stall/instr", instr, 32'h0810_0008);
            chk("stall/valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        // j with branch also taken: jump target 0x00400020 must win over 0x00400028
        redirect(2'd1, 1'b1, 1'b1, 32'h0);
        serve("j", 32'h0040_0020, 32'h03E0_0008, 0);

        redirect(2'd2, 1'b0, 1'b0, 32'h0040_0010);
        serve("beq_t", 32'h0040_0010, 32'h1000_FFFE, 0);
        redirect(2'd0, 1'b1, 1'b1, 32'h0);
        serve("taken", 32'h0040_000C, 32'h0000_0000, 0);
        redirect(2'd2, 1'b0, 1'b0, 32'h0040_0010);
        serve("beq_nt", 32'h0040_0010, 32'h1000_FFFE, 0);
        redirect(2'd0, 1'b1, 1'b0, 32'h0);
        serve("not_taken", 32'h0040_0014, 32'h0000_0000, 0);
        redirect(2'd3, 1'b0, 1'b0, 32'h1234_5678);
        serve("jump3", 32'h0040_0018, 32'h0000_0000, 0);

        redirect(2'd2, 1'b0, 1'b0, 32'hFFFF_FFFC);
        serve("top", 32'hFFFF_FFFC, 32'h0000_0000, 0);
        chk("wrap/pc4", pc_plus4, 32'h0);
        redirect(2'd0, 1'b0, 1'b0, 32'h0);
        chk("wrap/req", {31'd0, imem_req}, 32'd1);
        chk("wrap/addr", imem_addr, 32'h0);

        // reset while waiting; the late ack lands on the S_RST edge and must be ignored
        step();
        chk("wait/req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("wrst/req", {31'd0, imem_req}, 32'd0);
        chk("wrst/pc", pc, RPC);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        chk("late/instr", instr, 32'h0);
        chk("late/valid", {31'd0, instr_valid}, 32'd0);
        chk("late/req", {31'd0, imem_req}, 32'd1);
        chk("late/addr", imem_addr, RPC);
        serve("restart", RPC, 32'h2008_0005, 0);

        redirect(2'd2, 1'b0, 1'b0, 32'h0040_1002);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis/flag", {31'd0, misalign}, 32'd1);
        chk("mis/valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("mis/req", {31'd0, imem_req}, 32'd0);
            step();
        end
        chk("mis/sticky", {31'd0, misalign}, 32'd1);
`else
        serve("align", 32'h0040_1000, 32'h0000_0000, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
